// File: rtl/mem_wb_stage_if.sv
// Data-memory request/ready bus between the MEM stage (master) and the data memory (slave).
interface mem_wb_stage_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
);
  logic              dm_req;
  logic              dm_we;
  logic [ADDR_W-1:0] dm_addr;
  logic [DATA_W-1:0] dm_wdata;
  logic [3:0]        dm_bweb;
  logic              dm_ready;
  logic [DATA_W-1:0] dm_rdata;

  modport master (
    output dm_req, dm_we, dm_addr, dm_wdata, dm_bweb,
    input  dm_ready, dm_rdata
  );

  modport slave (
    input  dm_req, dm_we, dm_addr, dm_wdata, dm_bweb,
    output dm_ready, dm_rdata
  );
endinterface

// File: rtl/mem_wb_stage.sv
// MEM stage plus MEM/WB register: drives the data memory, stalls on wait states, formats loads.
// Optional MISALIGN_CHECK_EN suppresses misaligned H/W accesses and reports them on misalign_err.
module mem_wb_stage #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  EXEMEM_RDSrc,
  input  logic                  EXEMEM_MemtoReg,
  input  logic                  EXEMEM_MemRead,
  input  logic                  EXEMEM_MemWrite,
  input  logic                  EXEMEM_RegWrite,
  input  logic [ADDR_W-1:0]     EXEMEM_pc_to_reg,
  input  logic [DATA_W-1:0]     EXEMEM_ALU_out,
  input  logic [DATA_W-1:0]     EXEMEM_rs2_data,
  input  logic [REG_ADDR_W-1:0] EXEMEM_rd_addr,
  input  logic [2:0]            EXEMEM_funct3,
  mem_wb_stage_if.master        dm,
  output logic                  mem_stall,
  output logic [DATA_W-1:0]     Forward_EXEMEM,
  output logic [DATA_W-1:0]     Forward_MEMWB,
  output logic                  MEMWB_RegWrite,
  output logic [REG_ADDR_W-1:0] MEMWB_rd_addr,
  output logic [DATA_W-1:0]     MEMWB_rd_data
`ifdef MISALIGN_CHECK_EN
  ,
  output logic                  misalign_err
`endif
);

  localparam int NB = DATA_W / 8;

  typedef enum logic {IDLE, WAIT} state_t;
  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} size_t;

  state_t state, state_nxt;
  size_t  size;
  logic   mem_op, misalign, access, req, we;
  logic [1:0]              off;
  logic [3:0]              st_mask;
  logic [DATA_W-1:0]       st_data, load_fmt;
  logic [NB-1:0][7:0]      rword;
  logic [7:0]              ld_b;
  logic [15:0]             ld_h;

  assign off    = EXEMEM_ALU_out[1:0];
  assign mem_op = EXEMEM_MemRead | EXEMEM_MemWrite;

  // Write wins when both MemRead and MemWrite are set, so size decode follows the store table.
  always_comb begin
    size = SZ_W;
    if (EXEMEM_MemWrite) begin
      case (EXEMEM_funct3)
        3'b000:  size = SZ_B;
        3'b001:  size = SZ_H;
        default: size = SZ_W;
      endcase
    end else begin
      case (EXEMEM_funct3)
        3'b000, 3'b100: size = SZ_B;
        3'b001, 3'b101: size = SZ_H;
        default:        size = SZ_W;
      endcase
    end
  end

`ifdef MISALIGN_CHECK_EN
  assign misalign = mem_op & (((size == SZ_H) & off[0]) | ((size == SZ_W) & (off != 2'b00)));
`else
  assign misalign = 1'b0;
`endif

  assign access = mem_op & ~misalign;
  assign req    = ~rst & (access | (state == WAIT));
  assign we     = ~rst & EXEMEM_MemWrite;

  always_comb begin
    st_mask = 4'b0000;
    st_data = EXEMEM_rs2_data;
    case (size)
      SZ_B: begin
        st_mask = ~(4'b0001 << off);
        st_data = {NB{EXEMEM_rs2_data[7:0]}};
      end
      SZ_H: begin
        st_mask = off[1] ? 4'b0011 : 4'b1100;
        st_data = {(NB/2){EXEMEM_rs2_data[15:0]}};
      end
      default: begin
        st_mask = 4'b0000;
        st_data = EXEMEM_rs2_data;
      end
    endcase
  end

  assign dm.dm_req   = req;
  assign dm.dm_we    = we;
  assign dm.dm_addr  = {EXEMEM_ALU_out[ADDR_W-1:2], 2'b00};
  assign dm.dm_wdata = st_data;
  assign dm.dm_bweb  = (req & we) ? st_mask : 4'hF;
  assign mem_stall   = req & ~dm.dm_ready;

  assign rword = dm.dm_rdata;
  assign ld_b  = rword[off];
  assign ld_h  = off[1] ? {rword[3], rword[2]} : {rword[1], rword[0]};

  always_comb begin
    case (EXEMEM_funct3)
      3'b000:  load_fmt = {{(DATA_W-8){ld_b[7]}}, ld_b};
      3'b100:  load_fmt = {{(DATA_W-8){1'b0}}, ld_b};
      3'b001:  load_fmt = {{(DATA_W-16){ld_h[15]}}, ld_h};
      3'b101:  load_fmt = {{(DATA_W-16){1'b0}}, ld_h};
      default: load_fmt = dm.dm_rdata;
    endcase
  end

  assign Forward_EXEMEM = EXEMEM_RDSrc ? DATA_W'(EXEMEM_pc_to_reg) : EXEMEM_ALU_out;
  assign Forward_MEMWB  = MEMWB_rd_data;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (req & ~dm.dm_ready) state_nxt = WAIT;
      WAIT:    if (dm.dm_ready)        state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // A stalled cycle inserts a bubble; index and data hold so forwarding stays stable.
  always_ff @(posedge clk) begin
    if (rst) begin
      MEMWB_RegWrite <= 1'b0;
      MEMWB_rd_addr  <= '0;
      MEMWB_rd_data  <= '0;
    end else if (mem_stall) begin
      MEMWB_RegWrite <= 1'b0;
    end else begin
      MEMWB_RegWrite <= EXEMEM_RegWrite & ~misalign;
      MEMWB_rd_addr  <= EXEMEM_rd_addr;
      MEMWB_rd_data  <= EXEMEM_MemtoReg ? load_fmt : Forward_EXEMEM;
    end
  end

`ifdef MISALIGN_CHECK_EN
  always_ff @(posedge clk) begin
    if (rst) misalign_err <= 1'b0;
    else     misalign_err <= misalign;
  end
`endif

endmodule

// File: tb/tb_mem_wb_stage.sv
// Self-checking bench for mem_wb_stage: vector table with a MEMWB scoreboard plus stall/reset sequences.
module tb_mem_wb_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        rdsrc, m2r, mr, mw, rw;
  logic [31:0] pc, alu, rs2;
  logic [4:0]  rd;
  logic [2:0]  f3;
  logic        mem_stall, memwb_rw;
  logic [31:0] fwd_exmem, fwd_memwb, memwb_data;
  logic [4:0]  memwb_rd;
`ifdef MISALIGN_CHECK_EN
  logic        misalign_err;
`endif

  int checks   = 0;
  int failures = 0;

  mem_wb_stage_if #(.DATA_W(32), .ADDR_W(32)) dmif ();

  mem_wb_stage dut (
    .clk(clk), .rst(rst),
    .EXEMEM_RDSrc(rdsrc), .EXEMEM_MemtoReg(m2r), .EXEMEM_MemRead(mr),
    .EXEMEM_MemWrite(mw), .EXEMEM_RegWrite(rw), .EXEMEM_pc_to_reg(pc),
    .EXEMEM_ALU_out(alu), .EXEMEM_rs2_data(rs2), .EXEMEM_rd_addr(rd),
    .EXEMEM_funct3(f3), .dm(dmif), .mem_stall(mem_stall),
    .Forward_EXEMEM(fwd_exmem), .Forward_MEMWB(fwd_memwb),
    .MEMWB_RegWrite(memwb_rw), .MEMWB_rd_addr(memwb_rd), .MEMWB_rd_data(memwb_data)
`ifdef MISALIGN_CHECK_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog expired act=running exp=finished");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        rdsrc, m2r, mr, mw, rw;
    logic [31:0] pc, alu, rs2;
    logic [4:0]  rd;
    logic [2:0]  f3;
    logic [31:0] rdata;
    logic        e_req, e_we;
    logic [31:0] e_addr, e_wdata;
    logic [3:0]  e_bweb;
    logic [31:0] e_fwd;
    logic        e_rw;
    logic [31:0] e_data;
    logic        e_mis;
  } vec_t;

  typedef struct {
    logic        rw;
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_t;

  wb_t wb_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic s, input logic t, input logic r, input logic w, input logic g,
                       input logic [31:0] p, input logic [31:0] a, input logic [31:0] d,
                       input logic [4:0] dst, input logic [2:0] fn);
    rdsrc = s; m2r = t; mr = r; mw = w; rw = g;
    pc = p; alu = a; rs2 = d; rd = dst; f3 = fn;
  endtask

  localparam int NV = 18;
  vec_t vecs[NV];

  initial begin
    // rdsrc m2r mr mw rw pc alu rs2 rd f3 rdata | req we addr wdata bweb fwd rw data mis
    vecs[0]  = '{0,1,1,0,1, 32'h0, 32'h104, 32'h0, 5'd1, 3'b010, 32'hDEADBEEF, 1,0,32'h104,32'h0,4'hF,32'h104,1,32'hDEADBEEF,0};
    vecs[1]  = '{0,1,1,0,1, 32'h0, 32'h103, 32'h0, 5'd2, 3'b000, 32'h80123456, 1,0,32'h100,32'h0,4'hF,32'h103,1,32'hFFFFFF80,0};
    vecs[2]  = '{0,1,1,0,1, 32'h0, 32'h103, 32'h0, 5'd3, 3'b100, 32'h80123456, 1,0,32'h100,32'h0,4'hF,32'h103,1,32'h00000080,0};
    vecs[3]  = '{0,1,1,0,1, 32'h0, 32'h102, 32'h0, 5'd4, 3'b101, 32'h80123456, 1,0,32'h100,32'h0,4'hF,32'h102,1,32'h00008012,0};
    vecs[4]  = '{0,1,1,0,1, 32'h0, 32'h102, 32'h0, 5'd5, 3'b001, 32'h80123456, 1,0,32'h100,32'h0,4'hF,32'h102,1,32'hFFFF8012,0};
    vecs[5]  = '{0,1,1,0,1, 32'h0, 32'h100, 32'h0, 5'd6, 3'b001, 32'h80123456, 1,0,32'h100,32'h0,4'hF,32'h100,1,32'h00003456,0};
    vecs[6]  = '{0,1,1,0,1, 32'h0, 32'h101, 32'h0, 5'd7, 3'b000, 32'h80123456, 1,0,32'h100,32'h0,4'hF,32'h101,1,32'h00000034,0};
    vecs[7]  = '{0,1,1,0,1, 32'h0, 32'h100, 32'h0, 5'd8, 3'b000, 32'h801234A6, 1,0,32'h100,32'h0,4'hF,32'h100,1,32'hFFFFFFA6,0};
    vecs[8]  = '{0,0,0,1,0, 32'h0, 32'h200, 32'h11223344, 5'd9, 3'b010, 32'h0, 1,1,32'h200,32'h11223344,4'b0000,32'h200,0,32'h200,0};
    vecs[9]  = '{0,0,0,1,0, 32'h0, 32'h202, 32'h0000BEEF, 5'd10, 3'b001, 32'h0, 1,1,32'h200,32'hBEEFBEEF,4'b0011,32'h202,0,32'h202,0};
    vecs[10] = '{0,0,0,1,0, 32'h0, 32'h200, 32'h1234BEEF, 5'd11, 3'b001, 32'h0, 1,1,32'h200,32'hBEEFBEEF,4'b1100,32'h200,0,32'h200,0};
    vecs[11] = '{0,0,0,1,0, 32'h0, 32'h103, 32'h000000AB, 5'd12, 3'b000, 32'h0, 1,1,32'h100,32'hABABABAB,4'b0111,32'h103,0,32'h103,0};
    vecs[12] = '{1,0,0,0,1, 32'h208, 32'h1234, 32'h0, 5'd1, 3'b000, 32'h0, 0,0,32'h1234,32'h0,4'hF,32'h208,1,32'h208,0};
    vecs[13] = '{0,0,0,0,1, 32'h0, 32'hCAFE, 32'h0, 5'd0, 3'b000, 32'h0, 0,0,32'hCAFC,32'h0,4'hF,32'hCAFE,1,32'hCAFE,0};
    vecs[14] = '{0,0,1,1,0, 32'h0, 32'h300, 32'h55, 5'd13, 3'b010, 32'h0, 1,1,32'h300,32'h55,4'b0000,32'h300,0,32'h300,0};
`ifdef MISALIGN_CHECK_EN
    vecs[15] = '{0,1,1,0,1, 32'h0, 32'h102, 32'h0, 5'd14, 3'b010, 32'hA5A5C3C3, 0,0,32'h100,32'h0,4'hF,32'h102,0,32'hA5A5C3C3,1};
`else
    vecs[15] = '{0,1,1,0,1, 32'h0, 32'h102, 32'h0, 5'd14, 3'b010, 32'hA5A5C3C3, 1,0,32'h100,32'h0,4'hF,32'h102,1,32'hA5A5C3C3,0};
`endif
    vecs[16] = '{0,1,1,0,1, 32'h0, 32'h108, 32'h0, 5'd15, 3'b011, 32'h12345678, 1,0,32'h108,32'h0,4'hF,32'h108,1,32'h12345678,0};
    vecs[17] = '{0,1,1,0,1, 32'h0, 32'h10C, 32'h0, 5'd16, 3'b010, 32'h00C0FFEE, 1,0,32'h10C,32'h0,4'hF,32'h10C,1,32'h00C0FFEE,0};

    // Reset: memory controls quiet even with a store pending and memory not ready
    rst = 1'b1;
    drive(0, 0, 1, 1, 1, 32'h0, 32'h100, 32'hFF, 5'd3, 3'b010);
    dmif.dm_ready = 1'b0; dmif.dm_rdata = 32'h0;
    @(negedge clk); #1;
    chk("rst_req",   32'(dmif.dm_req), 32'h0);
    chk("rst_stall", 32'(mem_stall), 32'h0);
    chk("rst_we",    32'(dmif.dm_we), 32'h0);
    chk("rst_bweb",  32'(dmif.dm_bweb), 32'hF);
    @(posedge clk); #1;
    chk("rst_rw",   32'(memwb_rw), 32'h0);
    chk("rst_rd",   32'(memwb_rd), 32'h0);
    chk("rst_data", memwb_data, 32'h0);
`ifdef MISALIGN_CHECK_EN
    chk("rst_mis", 32'(misalign_err), 32'h0);
`endif
    @(negedge clk); rst = 1'b0;

    // Zero-wait vector table
    for (int i = 0; i < NV; i++) begin
      wb_t w;
      @(negedge clk);
      drive(vecs[i].rdsrc, vecs[i].m2r, vecs[i].mr, vecs[i].mw, vecs[i].rw,
            vecs[i].pc, vecs[i].alu, vecs[i].rs2, vecs[i].rd, vecs[i].f3);
      dmif.dm_ready = 1'b1; dmif.dm_rdata = vecs[i].rdata;
      #1;
      chk($sformatf("v%0d_req", i),   32'(dmif.dm_req), 32'(vecs[i].e_req));
      chk($sformatf("v%0d_stall", i), 32'(mem_stall), 32'h0);
      chk($sformatf("v%0d_fwd", i),   fwd_exmem, vecs[i].e_fwd);
      chk($sformatf("v%0d_bweb", i),  32'(dmif.dm_bweb), 32'(vecs[i].e_bweb));
      if (vecs[i].e_req) begin
        chk($sformatf("v%0d_we", i),   32'(dmif.dm_we), 32'(vecs[i].e_we));
        chk($sformatf("v%0d_addr", i), dmif.dm_addr, vecs[i].e_addr);
        if (vecs[i].e_we) chk($sformatf("v%0d_wdata", i), dmif.dm_wdata, vecs[i].e_wdata);
      end
      wb_q.push_back('{vecs[i].e_rw, vecs[i].rd, vecs[i].e_data});
      @(posedge clk); #1;
      w = wb_q.pop_front();
      chk($sformatf("v%0d_wb_rw", i),   32'(memwb_rw), 32'(w.rw));
      chk($sformatf("v%0d_wb_rd", i),   32'(memwb_rd), 32'(w.rd));
      chk($sformatf("v%0d_wb_data", i), memwb_data, w.data);
      chk($sformatf("v%0d_fwd_wb", i),  fwd_memwb, w.data);
`ifdef MISALIGN_CHECK_EN
      chk($sformatf("v%0d_mis", i), 32'(misalign_err), 32'(vecs[i].e_mis));
`endif
    end

    // Known MEMWB contents before the stalled store
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h0, 32'h77, 32'h0, 5'd9, 3'b000);
    dmif.dm_ready = 1'b1;
    @(posedge clk); #1;
    chk("pre_sb_data", memwb_data, 32'h77);

    // SB with three wait cycles
    @(negedge clk);
    drive(0, 0, 0, 1, 0, 32'h0, 32'h101, 32'h000000AB, 5'd3, 3'b000);
    dmif.dm_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k != 0) @(negedge clk);
      #1;
      chk($sformatf("sb%0d_stall", k), 32'(mem_stall), 32'h1);
      chk($sformatf("sb%0d_req", k),   32'(dmif.dm_req), 32'h1);
      chk($sformatf("sb%0d_we", k),    32'(dmif.dm_we), 32'h1);
      chk($sformatf("sb%0d_bweb", k),  32'(dmif.dm_bweb), 32'hD);
      chk($sformatf("sb%0d_wdata", k), dmif.dm_wdata, 32'hABABABAB);
      chk($sformatf("sb%0d_addr", k),  dmif.dm_addr, 32'h100);
      @(posedge clk); #1;
      chk($sformatf("sb%0d_wb_rw", k),   32'(memwb_rw), 32'h0);
      chk($sformatf("sb%0d_wb_rd", k),   32'(memwb_rd), 32'd9);
      chk($sformatf("sb%0d_wb_data", k), memwb_data, 32'h77);
    end
    @(negedge clk); dmif.dm_ready = 1'b1; #1;
    chk("sb_done_stall", 32'(mem_stall), 32'h0);
    chk("sb_done_req",   32'(dmif.dm_req), 32'h1);
    chk("sb_done_bweb",  32'(dmif.dm_bweb), 32'hD);
    @(posedge clk); #1;
    chk("sb_done_rd",   32'(memwb_rd), 32'd3);
    chk("sb_done_data", memwb_data, 32'h101);
    @(negedge clk);
    drive(0, 0, 0, 0, 1, 32'h0, 32'h5, 32'h0, 5'd4, 3'b000);
    dmif.dm_ready = 1'b0; #1;
    chk("sb_idle_req", 32'(dmif.dm_req), 32'h0);
    @(posedge clk); #1;
    chk("sb_idle_rw", 32'(memwb_rw), 32'h1);

    // Reset while an LW is waiting
    @(negedge clk);
    drive(0, 1, 1, 0, 1, 32'h0, 32'h104, 32'h0, 5'd7, 3'b010);
    dmif.dm_ready = 1'b0; #1;
    chk("rw_stall", 32'(mem_stall), 32'h1);
    @(posedge clk);
    @(negedge clk); rst = 1'b1; #1;
    chk("rw_rst_req",   32'(dmif.dm_req), 32'h0);
    chk("rw_rst_stall", 32'(mem_stall), 32'h0);
    chk("rw_rst_bweb",  32'(dmif.dm_bweb), 32'hF);
    @(posedge clk); #1;
    chk("rw_rst_rw",   32'(memwb_rw), 32'h0);
    chk("rw_rst_rd",   32'(memwb_rd), 32'h0);
    chk("rw_rst_data", memwb_data, 32'h0);
    @(negedge clk); rst = 1'b0;
    drive(0, 0, 0, 0, 0, 32'h0, 32'h44, 32'h0, 5'd2, 3'b000);
    dmif.dm_ready = 1'b0; #1;
    chk("rw_idle_req",   32'(dmif.dm_req), 32'h0);
    chk("rw_idle_stall", 32'(mem_stall), 32'h0);
    @(posedge clk);
    @(negedge clk);
    drive(0, 1, 1, 0, 1, 32'h0, 32'h104, 32'h0, 5'd7, 3'b010);
    dmif.dm_ready = 1'b1; dmif.dm_rdata = 32'h0BADF00D; #1;
    chk("rw_lw_req",   32'(dmif.dm_req), 32'h1);
    chk("rw_lw_stall", 32'(mem_stall), 32'h0);
    @(posedge clk); #1;
    chk("rw_lw_rw",   32'(memwb_rw), 32'h1);
    chk("rw_lw_rd",   32'(memwb_rd), 32'd7);
    chk("rw_lw_data", memwb_data, 32'h0BADF00D);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
